// File: rtl/seq_subtractor.sv
// Digit-serial subtractor: diff = a - b - bin, DIGIT bits per clock.
// Operands in and result out through valid/ready handshakes.
module seq_subtractor #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH ||
      (WIDTH % DIGIT) != 0) begin : g_bad_cfg
    $error("seq_subtractor: illegal WIDTH/DIGIT");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic [DIGIT:0]   slice;
  logic             last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operands shift down so the active digit always sits at bit 0.
  always_comb begin
    slice  = {1'b0, a_q[DIGIT-1:0]}
           - {1'b0, b_q[DIGIT-1:0]}
           - {{DIGIT{1'b0}}, brw_q};
    last   = (state_q == RUN) &&
             (cnt_q == CW'(NDIG - 1));
    a_d    = a_q;
    b_d    = b_q;
    diff_d = diff_q;
    cnt_d  = cnt_q;
    brw_d  = brw_q;
    bout_d = bout_q;
    ovf_d  = ovf_q;
    zero_d = zero_q;
    if (state_q == IDLE && in_valid) begin
      a_d   = a;
      b_d   = b;
      brw_d = bin;
      cnt_d = '0;
    end else if (state_q == RUN) begin
      a_d   = a_q >> DIGIT;
      b_d   = b_q >> DIGIT;
      brw_d = slice[DIGIT];
      cnt_d = cnt_q + 1'b1;
      for (int k = 0; k < NDIG; k++) begin
        if (int'(cnt_q) == k)
          diff_d[k*DIGIT +: DIGIT] = slice[DIGIT-1:0];
      end
      // Sign rule on the top digit equals MSB borrow-in xor borrow-out.
      if (last) begin
        bout_d = slice[DIGIT];
        ovf_d  = (a_q[DIGIT-1] ^ b_q[DIGIT-1]) &
                 (slice[DIGIT-1] ^ a_q[DIGIT-1]);
        zero_d = (diff_d == '0);
      end
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    diff      = diff_q;
    bout      = bout_q;
    ovf       = ovf_q;
    zero      = zero_q;
  end

endmodule

// File: tb/tb_seq_subtractor.sv
// Scoreboard bench for seq_subtractor.
// Instances: DIGIT=4 (directed), DIGIT=1 and DIGIT=16 (random vs model).
module tb_seq_subtractor;

  logic        clk;
  logic        rst_n;
  logic [15:0] a_i, b_i;
  logic        bin_i;
  logic        out_ready;
  logic        iv  [3];
  logic        ir  [3];
  logic        ov  [3];
  logic [15:0] dif [3];
  logic        bo  [3];
  logic        ovf [3];
  logic        zr  [3];

  seq_subtractor #(.WIDTH(16), .DIGIT(4)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a_i), .b(b_i), .bin(bin_i),
    .out_valid(ov[0]), .out_ready(out_ready),
    .diff(dif[0]), .bout(bo[0]), .ovf(ovf[0]), .zero(zr[0])
  );

  seq_subtractor #(.WIDTH(16), .DIGIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a_i), .b(b_i), .bin(bin_i),
    .out_valid(ov[1]), .out_ready(out_ready),
    .diff(dif[1]), .bout(bo[1]), .ovf(ovf[1]), .zero(zr[1])
  );

  seq_subtractor #(.WIDTH(16), .DIGIT(16)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[2]), .in_ready(ir[2]),
    .a(a_i), .b(b_i), .bin(bin_i),
    .out_valid(ov[2]), .out_ready(out_ready),
    .diff(dif[2]), .bout(bo[2]), .ovf(ovf[2]), .zero(zr[2])
  );

  typedef struct {
    int          idx;
    logic [15:0] d;
    logic        b;
    logic        o;
    logic        z;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   acc_edge [3];
  logic ov_prev  [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Monitor: latency on rising out_valid, stable outputs while held.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        if (iv[i] && ir[i]) acc_edge[i] = cyc + 1;
        if (ov[i]) begin
          if (q.size() == 0) begin
            chk("unexpected_out_valid", 32'(ov[i]), 0);
          end else begin
            chk("out_idx", i, q[0].idx);
            if (!ov_prev[i])
              chk("latency", cyc - acc_edge[i], q[0].lat);
            chk("in_ready_in_done", 32'(ir[i]), 0);
            chk("diff", 32'(dif[i]), 32'(q[0].d));
            chk("bout", 32'(bo[i]), 32'(q[0].b));
            chk("ovf", 32'(ovf[i]), 32'(q[0].o));
            chk("zero", 32'(zr[i]), 32'(q[0].z));
            if (out_ready) void'(q.pop_front());
          end
        end
        ov_prev[i] = ov[i];
      end
    end else begin
      for (int i = 0; i < 3; i++) ov_prev[i] = 1'b0;
    end
  end

  task automatic wait_for(input int idx, input bit want_ov);
    int n;
    n = 0;
    while (((want_ov ? ov[idx] : ir[idx]) !== 1'b1) &&
           n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 64) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: dut%0d %s never high",
               idx, want_ov ? "out_valid" : "in_ready");
    end
  endtask

  function automatic int lat_of(input int idx);
    return (idx == 0) ? 4 : (idx == 1) ? 16 : 1;
  endfunction

  task automatic run_op(input int idx,
                        input logic [15:0] a,
                        input logic [15:0] b,
                        input logic bi,
                        input logic [15:0] ed,
                        input logic eb,
                        input logic eo,
                        input logic ez,
                        input int hold);
    exp_t e;
    wait_for(idx, 1'b0);
    a_i = a;
    b_i = b;
    bin_i = bi;
    iv[idx] = 1'b1;
    e.idx = idx;
    e.d = ed;
    e.b = eb;
    e.o = eo;
    e.z = ez;
    e.lat = lat_of(idx);
    q.push_back(e);
    @(posedge clk);
    #1;
    iv[idx] = 1'b0;
    wait_for(idx, 1'b1);
    // Stall in DONE while offering new operands that must be ignored.
    for (int h = 0; h < hold; h++) begin
      a_i = ~a_i;
      b_i = b_i + 16'h1111;
      bin_i = ~bin_i;
      iv[idx] = 1'b1;
      @(posedge clk);
      #1;
    end
    iv[idx] = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("out_valid_drop", 32'(ov[idx]), 0);
    chk("in_ready_rise", 32'(ir[idx]), 1);
    chk("diff_hold_idle", 32'(dif[idx]), 32'(ed));
  endtask

  initial begin
    logic [16:0] t;
    logic [15:0] ra, rb, ed;
    logic        rbi, eo;
    rst_n = 1'b0;
    a_i = '0;
    b_i = '0;
    bin_i = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0;
      acc_edge[i] = 0;
      ov_prev[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_in_ready", 32'(ir[i]), 1);
      chk("rst_out_valid", 32'(ov[i]), 0);
      chk("rst_diff", 32'(dif[i]), 0);
      chk("rst_flags", {bo[i], ovf[i], zr[i]}, 0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op(0, 16'h0003, 16'h0009, 1'b0, 16'hFFFA, 1, 0, 0, 0);
    run_op(0, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 0, 1, 0, 0);
    run_op(0, 16'h000B, 16'h000A, 1'b1, 16'h0000, 0, 0, 1, 0);
    run_op(0, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1, 0, 0, 0);
    run_op(0, 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1, 1, 0, 1);
    run_op(0, 16'hA5A5, 16'h5A5A, 1'b0, 16'h4B4B, 0, 1, 0, 5);

    // Reset after two digits of a run.
    wait_for(0, 1'b0);
    a_i = 16'h1234;
    b_i = 16'h0F0F;
    bin_i = 1'b1;
    iv[0] = 1'b1;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_out_valid", 32'(ov[0]), 0);
    chk("midrun_rst_in_ready", 32'(ir[0]), 1);
    chk("midrun_rst_diff", 32'(dif[0]), 0);
    chk("midrun_rst_flags", {bo[0], ovf[0], zr[0]}, 0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op(0, 16'h1234, 16'h0F0F, 1'b1, 16'h0324, 0, 0, 0, 0);

    for (int idx = 1; idx < 3; idx++) begin
      for (int n = 0; n < 200; n++) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
        rbi = 1'($urandom);
        if (n == 0) begin
          ra = 16'h0000;
          rb = 16'h0000;
          rbi = 1'b1;
        end
        t = {1'b0, ra} - {1'b0, rb} - {16'h0, rbi};
        ed = t[15:0];
        eo = (ra[15] ^ rb[15]) & (ed[15] ^ ra[15]);
        run_op(idx, ra, rb, rbi, ed, t[16], eo,
               (ed == 16'h0), (n % 8 == 0) ? 2 : 0);
      end
    end

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
